// File: rtl/aclk_controller.sv
// Keypad/button sequencing FSM for the alarm clock: builds a 4-digit BCD entry
// buffer and issues display-mode and one-cycle load strobes for the LCD driver.
module aclk_controller #(
  parameter int unsigned TIMEOUT_SEC = 10,
  parameter logic [3:0]  NOKEY       = 4'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        one_second,
  input  logic [3:0]  key,
  input  logic        alarm_button,
  input  logic        time_button,
  output logic        show_new_time,
  output logic        show_alarm,
  output logic        load_new_time,
  output logic        load_alarm,
  output logic        shift,
  output logic [15:0] new_time
);

  typedef enum logic [2:0] {
    SHOW_TIME,
    SHOW_ALARM,
    KEY_STORED,
    KEY_WAITED,
    KEY_ENTRY,
    LD_ALARM,
    LD_TIME
  } state_t;

  localparam logic [3:0] LP_TIMEOUT = 4'(TIMEOUT_SEC);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_count;
  logic [15:0] r_new_time;
  logic        r_show_new_time;
  logic        r_show_alarm;
  logic        r_load_new_time;
  logic        r_load_alarm;
  logic        r_shift;

  logic w_digit;
  logic w_timeout;
  logic w_shift_in;
  logic w_first_digit;
  logic w_show_new_time;
  logic w_show_alarm;
  logic w_load_new_time;
  logic w_load_alarm;
  logic w_shift;

  // Codes 11-15 behave exactly like NOKEY: they never count as a digit.
  assign w_digit   = (key <= 4'd9) && (key != NOKEY);
  assign w_timeout = (r_count == LP_TIMEOUT);

  always_comb begin
    w_next        = r_state;
    w_shift_in    = 1'b0;
    w_first_digit = 1'b0;
    case (r_state)
      SHOW_TIME: begin
        if (alarm_button) begin
          w_next = SHOW_ALARM;
        end else if (w_digit) begin
          w_next        = KEY_STORED;
          w_shift_in    = 1'b1;
          w_first_digit = 1'b1;
        end
      end
      SHOW_ALARM: begin
        if (!alarm_button) w_next = SHOW_TIME;
      end
      KEY_STORED: w_next = KEY_WAITED;
      KEY_WAITED: begin
        if (!w_digit)       w_next = KEY_ENTRY;
        else if (w_timeout) w_next = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (alarm_button) begin
          w_next = LD_ALARM;
        end else if (time_button) begin
          w_next = LD_TIME;
        end else if (w_digit) begin
          w_next     = KEY_STORED;
          w_shift_in = 1'b1;
        end else if (w_timeout) begin
          w_next = SHOW_TIME;
        end
      end
      LD_ALARM: w_next = SHOW_TIME;
      LD_TIME:  w_next = SHOW_TIME;
      default:  w_next = SHOW_TIME;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    w_show_new_time = 1'b0;
    w_show_alarm    = 1'b0;
    w_load_new_time = 1'b0;
    w_load_alarm    = 1'b0;
    w_shift         = 1'b0;
    case (w_next)
      SHOW_ALARM: w_show_alarm = 1'b1;
      KEY_STORED: begin
        w_shift         = 1'b1;
        w_show_new_time = 1'b1;
      end
      KEY_WAITED: w_show_new_time = 1'b1;
      KEY_ENTRY:  w_show_new_time = 1'b1;
      LD_ALARM: begin
        w_load_alarm    = 1'b1;
        w_show_new_time = 1'b1;
      end
      LD_TIME: begin
        w_load_new_time = 1'b1;
        w_show_new_time = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= SHOW_TIME;
      r_count         <= 4'd0;
      r_new_time      <= 16'h0000;
      r_show_new_time <= 1'b0;
      r_show_alarm    <= 1'b0;
      r_load_new_time <= 1'b0;
      r_load_alarm    <= 1'b0;
      r_shift         <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_show_new_time <= w_show_new_time;
      r_show_alarm    <= w_show_alarm;
      r_load_new_time <= w_load_new_time;
      r_load_alarm    <= w_load_alarm;
      r_shift         <= w_shift;
      if (w_shift_in) begin
        r_new_time <= w_first_digit ? {12'h000, key} : {r_new_time[11:0], key};
      end
      // A second pulse landing with a digit is dropped: the restart wins.
      if (w_next == KEY_STORED || !(r_state == KEY_WAITED || r_state == KEY_ENTRY)) begin
        r_count <= 4'd0;
      end else if (one_second && !w_timeout) begin
        r_count <= r_count + 4'd1;
      end
    end
  end

  assign show_new_time = r_show_new_time;
  assign show_alarm    = r_show_alarm;
  assign load_new_time = r_load_new_time;
  assign load_alarm    = r_load_alarm;
  assign shift         = r_shift;
  assign new_time      = r_new_time;

endmodule

// File: tb/tb_aclk_controller.sv
// Self-checking bench for aclk_controller: hand-derived expected outputs are
// queued as each cycle's stimulus is driven and compared after the clock edge.
module tb_aclk_controller;

  localparam logic [3:0] NOKEY = 4'd10;
  // Flag order: {show_new_time, show_alarm, load_new_time, load_alarm, shift}
  localparam logic [4:0] F_IDLE  = 5'b00000;
  localparam logic [4:0] F_ALM   = 5'b01000;
  localparam logic [4:0] F_SHIFT = 5'b10001;
  localparam logic [4:0] F_SHOW  = 5'b10000;
  localparam logic [4:0] F_LDT   = 5'b10100;
  localparam logic [4:0] F_LDA   = 5'b10010;

  typedef struct {
    logic [3:0]  key;
    logic        ab;
    logic        tb;
    logic        os;
    logic [4:0]  flags;
    logic [15:0] nt;
  } vec_t;

  typedef struct {
    logic [4:0]  flags;
    logic [15:0] nt;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        oneSecond;
  logic [3:0]  key;
  logic        alarmButton;
  logic        timeButton;
  logic        showNewTime;
  logic        showAlarm;
  logic        loadNewTime;
  logic        loadAlarm;
  logic        shiftOut;
  logic [15:0] newTime;

  exp_t expQ[$];
  vec_t table1[$];
  int   total = 0;
  int   bad   = 0;

  aclk_controller #(.TIMEOUT_SEC(10), .NOKEY(4'd10)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .one_second    (oneSecond),
    .key           (key),
    .alarm_button  (alarmButton),
    .time_button   (timeButton),
    .show_new_time (showNewTime),
    .show_alarm    (showAlarm),
    .load_new_time (loadNewTime),
    .load_alarm    (loadAlarm),
    .shift         (shiftOut),
    .new_time      (newTime)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic applyStimulus(input logic [3:0] k, input logic ab, input logic tb,
                               input logic os, input logic [4:0] flags,
                               input logic [15:0] nt, input string name);
    exp_t e;
    key         = k;
    alarmButton = ab;
    timeButton  = tb;
    oneSecond   = os;
    e.flags = flags;
    e.nt    = nt;
    e.name  = name;
    expQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [4:0] act;
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL scoreboard: no expected entry queued at t=%0t", $time);
      return;
    end
    e   = expQ.pop_front();
    act = {showNewTime, showAlarm, loadNewTime, loadAlarm, shiftOut};
    if (act !== e.flags || newTime !== e.nt) begin
      bad++;
      $display("[TB] FAIL %s: got flags=%b new_time=%h, want flags=%b new_time=%h (t=%0t)",
               e.name, act, newTime, e.flags, e.nt, $time);
    end
  endtask

  task automatic step(input logic [3:0] k, input logic ab, input logic tb, input logic os,
                      input logic [4:0] flags, input logic [15:0] nt, input string name);
    applyStimulus(k, ab, tb, os, flags, nt, name);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Enter a digit and release it; ends in the entry-waiting state.
  task automatic enterDigit(input logic [3:0] d, input logic os, input logic [15:0] nt,
                            input string name);
    step(d, 1'b0, 1'b0, os, F_SHIFT, nt, name);
    step(NOKEY, 1'b0, 1'b0, 1'b0, F_SHOW, nt, name);
    step(NOKEY, 1'b0, 1'b0, 1'b0, F_SHOW, nt, name);
  endtask

  task automatic pulses(input int n, input logic [15:0] nt, input string name);
    for (int i = 0; i < n; i++) begin
      step(NOKEY, 1'b0, 1'b0, 1'b1, F_SHOW, nt, name);
      step(NOKEY, 1'b0, 1'b0, 1'b0, F_SHOW, nt, name);
    end
  endtask

  function automatic vec_t mkVec(input logic [3:0] k, input logic ab, input logic tb,
                                 input logic os, input logic [4:0] flags,
                                 input logic [15:0] nt);
    vec_t v;
    v.key = k; v.ab = ab; v.tb = tb; v.os = os; v.flags = flags; v.nt = nt;
    return v;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  digits[4];
    logic [15:0] nt;

    // Entry of 1,2,3,0 (held 3 cycles, 2 idle cycles between) then a time load.
    digits[0] = 4'd1; digits[1] = 4'd2; digits[2] = 4'd3; digits[3] = 4'd0;
    nt = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      nt = {nt[11:0], digits[i]};
      table1.push_back(mkVec(digits[i], 1'b0, 1'b0, 1'b0, F_SHIFT, nt));
      table1.push_back(mkVec(digits[i], 1'b0, 1'b0, 1'b0, F_SHOW, nt));
      table1.push_back(mkVec(digits[i], 1'b0, 1'b0, 1'b0, F_SHOW, nt));
      table1.push_back(mkVec(NOKEY, 1'b0, 1'b0, 1'b0, F_SHOW, nt));
      table1.push_back(mkVec(NOKEY, 1'b0, 1'b0, 1'b0, F_SHOW, nt));
    end
    table1.push_back(mkVec(NOKEY, 1'b0, 1'b1, 1'b0, F_LDT, 16'h1230));
    table1.push_back(mkVec(NOKEY, 1'b0, 1'b0, 1'b0, F_IDLE, 16'h1230));

    // Reset with a key and the alarm button active.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step(4'd5, 1'b1, 1'b0, 1'b0, F_IDLE, 16'h0000, "reset");
    rst_n = 1'b1;
    step(NOKEY, 1'b0, 1'b0, 1'b0, F_IDLE, 16'h0000, "reset_release");

    for (int i = 0; i < table1.size(); i++) begin
      step(table1[i].key, table1[i].ab, table1[i].tb, table1[i].os,
           table1[i].flags, table1[i].nt, $sformatf("entry_vec%0d", i));
    end

    // Alarm display while held, with a digit that must be ignored.
    for (int i = 0; i < 5; i++) step(4'd4, 1'b1, 1'b0, 1'b0, F_ALM, 16'h1230, "alarm_hold");
    step(NOKEY, 1'b0, 1'b0, 1'b0, F_IDLE, 16'h1230, "alarm_release");

    // First digit 0 must clear the old buffer; then load alarm with 0645.
    enterDigit(4'd0, 1'b0, 16'h0000, "first_digit_clear");
    enterDigit(4'd6, 1'b0, 16'h0006, "alarm_entry");
    enterDigit(4'd4, 1'b0, 16'h0064, "alarm_entry");
    enterDigit(4'd5, 1'b0, 16'h0645, "alarm_entry");
    step(NOKEY, 1'b1, 1'b0, 1'b0, F_LDA, 16'h0645, "load_alarm");
    step(NOKEY, 1'b0, 1'b0, 1'b0, F_IDLE, 16'h0645, "after_load_alarm");

    // Held key shifts once only.
    step(4'd7, 1'b0, 1'b0, 1'b0, F_SHIFT, 16'h0007, "held_key_first");
    for (int i = 0; i < 19; i++) step(4'd7, 1'b0, 1'b0, 1'b0, F_SHOW, 16'h0007, "held_key");
    step(NOKEY, 1'b0, 1'b0, 1'b0, F_SHOW, 16'h0007, "held_key_release");

    // Timeout: 9 pulses keep the entry, the 10th abandons it one cycle later.
    pulses(9, 16'h0007, "timeout_9");
    step(NOKEY, 1'b0, 1'b0, 1'b1, F_SHOW, 16'h0007, "timeout_10th");
    step(NOKEY, 1'b0, 1'b0, 1'b0, F_IDLE, 16'h0007, "timeout_exit");
    step(NOKEY, 1'b0, 1'b0, 1'b0, F_IDLE, 16'h0007, "timeout_stay");

    // A digit (with a coincident pulse) restarts the count.
    enterDigit(4'd3, 1'b0, 16'h0003, "restart_first");
    pulses(9, 16'h0003, "restart_9");
    enterDigit(4'd2, 1'b1, 16'h0032, "restart_digit");
    pulses(9, 16'h0032, "restart_again_9");
    step(NOKEY, 1'b0, 1'b0, 1'b0, F_SHOW, 16'h0032, "restart_not_expired");
    step(NOKEY, 1'b0, 1'b0, 1'b1, F_SHOW, 16'h0032, "restart_10th");
    step(NOKEY, 1'b0, 1'b0, 1'b0, F_IDLE, 16'h0032, "restart_exit");

    // Both buttons plus a digit: alarm load only, no shift.
    enterDigit(4'd9, 1'b0, 16'h0009, "prio_entry");
    step(4'd4, 1'b1, 1'b1, 1'b0, F_LDA, 16'h0009, "prio_buttons_digit");
    step(NOKEY, 1'b0, 1'b0, 1'b0, F_IDLE, 16'h0009, "prio_after");

    // Five digits: the oldest falls out of the top nibble.
    enterDigit(4'd9, 1'b0, 16'h0009, "overflow");
    enterDigit(4'd8, 1'b0, 16'h0098, "overflow");
    enterDigit(4'd7, 1'b0, 16'h0987, "overflow");
    enterDigit(4'd6, 1'b0, 16'h9876, "overflow");
    enterDigit(4'd5, 1'b0, 16'h8765, "overflow");
    step(4'd12, 1'b0, 1'b1, 1'b0, F_LDT, 16'h8765, "overflow_load_time");
    step(NOKEY, 1'b0, 1'b0, 1'b0, F_IDLE, 16'h8765, "overflow_after");

    // Reset in the middle of an entry discards the pending load.
    enterDigit(4'd1, 1'b0, 16'h0001, "midreset_entry");
    rst_n = 1'b0;
    step(NOKEY, 1'b0, 1'b1, 1'b0, F_IDLE, 16'h0000, "midreset");
    rst_n = 1'b1;
    step(NOKEY, 1'b0, 1'b0, 1'b0, F_IDLE, 16'h0000, "midreset_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
